regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the core pipeline with a hardware init sweep, a per-register pending scoreboard, and configurable read/write port counts. Decode reads operands from it; writeback drives the write ports. Same-cycle writes are forwarded to readers, and decode gets a busy flag per operand for hazard stalls.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers (power of two, ≥2); AW = log2(NREGS)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- ZERO_HARD, 1, register 0 is hardwired to zero when 1

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset (sampled on posedge clk)
- we_i  in  NWR  per-port write enable
- waddr_i  in  NWR*AW  per-port write address; port k uses bits [k*AW +: AW]
- wdata_i  in  NWR*XLEN  per-port write data
- raddr_i  in  NRD*AW  per-port read address
- rdata_o  out  NRD*XLEN  per-port read data, combinational
- rbusy_o  out  NRD  read register has a pending producer not satisfied this cycle
- issue_i  in  1  an instruction with destination issue_rd_i is issued this cycle
- issue_rd_i  in  AW  destination register of the issued instruction
- ready_o  out  1  init sweep complete; block accepts writes and issues

## Operation
- States: INIT, RUN. Sweep counter cnt, AW+1 bits.
- rst low at a posedge: state ← INIT, cnt ← 0, pending ← all 0, ready_o ← 0. Array contents are not reset directly.
- INIT, rst high: regs[cnt] ← 0, cnt ← cnt+1. When cnt == NREGS-1, go to RUN on the same edge. we_i and issue_i are ignored. All rdata_o read 0 and all rbusy_o read 0.
- RUN: ready_o = 1.
- Write ports:
  - Port k writes regs[waddr_k] ← wdata_k when we_k is high.
  - With ZERO_HARD, writes to address 0 are dropped.
  - If several ports target the same address, the highest-index port wins.
- Read port j, in priority order:
  - raddr_j == 0 with ZERO_HARD: returns 0.
  - Else, any enabled write port with waddr == raddr_j: returns the data of the highest-index such port (bypass).
  - Else: returns regs[raddr_j].
- Scoreboard:
  - issue_i with issue_rd_i ≠ 0 (or any address when ZERO_HARD=0) sets pending[issue_rd_i].
  - Any enabled write to address a clears pending[a].
  - If set and clear hit the same register in one cycle, set wins: the new producer supersedes.
- rbusy_o[j] = pending[raddr_j] AND no enabled write to raddr_j this cycle, AND NOT (ZERO_HARD and raddr_j == 0).

## Timing
- Reset values: ready_o = 0, rbusy_o = 0, rdata_o = 0 (while in INIT).
- Init latency: ready_o rises exactly NREGS posedges after the first posedge with rst high.
- Write-to-array latency is 1 cycle. Same-cycle visibility to readers is via bypass, with zero latency.
- Issue-to-busy latency is 1 cycle: rbusy_o reflects the issue from the previous edge.
- rst asserted mid-RUN or mid-INIT: the next edge re-enters INIT with cnt = 0 and pending cleared. Writes in that cycle are discarded.
- rdata_o and rbusy_o are purely combinational from addresses, write ports, pending and the array. There is no combinational path from issue_i to any output.

## Test plan
- Reset/init:
  - Hold rst=0 for 3 cycles, then release.
  - Required: ready_o=0 for cycles 1..31, ready_o=1 after the 32nd edge.
  - Required: reading every register afterwards returns 0, even if the array was preloaded with 0xDEADBEEF.
- Dual-write conflict:
  - Both ports write x5 (port0 0x11111111, port1 0x22222222).
  - Required: the same-cycle read of x5 returns 0x22222222, and it still reads 0x22222222 next cycle.
- Bypass and x0:
  - Port0 writes x0 ← 0xFFFFFFFF, port1 writes x7 ← 0x1234.
  - Required: read x0 = 0 in this and later cycles; read x7 = 0x1234 in the same cycle.
- Scoreboard:
  - issue_i, rd=9 at cycle n: rbusy for x9 = 1 from cycle n+1.
  - Write x9 at cycle n+3: rbusy for x9 = 0 in cycle n+3 (bypass) and after.
  - Simultaneous issue rd=9 and write x9: x9 stays busy.
- Init-phase blocking:
  - we_i and issue_i driven during INIT.
  - Required: no register modified, no pending bit set, ready_o timing unchanged.
- Reset mid-operation:
  - x3=0xABCD, x4 pending, then a 1-cycle rst pulse.
  - Required: full NREGS-cycle sweep again, x3 reads 0, x4 not busy.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: zero-init sweep after reset, write-port
// forwarding to readers, and a per-register pending scoreboard for hazard stalls.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NRD       = 2,
  parameter int NWR       = 2,
  parameter int ZERO_HARD = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       we_i,
  input  logic [NWR*AW-1:0]    waddr_i,
  input  logic [NWR*XLEN-1:0]  wdata_i,
  input  logic [NRD*AW-1:0]    raddr_i,
  output logic [NRD*XLEN-1:0]  rdata_o,
  output logic [NRD-1:0]       rbusy_o,
  input  logic                 issue_i,
  input  logic [AW-1:0]        issue_rd_i,
  output logic                 ready_o
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(NREGS - 1);

  state_t            state_q, state_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic              run_s;
  logic [NWR-1:0]    wr_en_s;
  logic              issue_ok_s;

  assign run_s      = (state_q == ST_RUN);
  assign wr_en_s    = run_s ? we_i : {NWR{1'b0}};
  assign issue_ok_s = run_s && issue_i && ((ZERO_HARD == 0) || (issue_rd_i != {AW{1'b0}}));
  assign ready_o    = ready_q;

  // Sweep FSM next state: INIT zeroes one register per edge, then RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + (AW+1)'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Scoreboard next state: writes clear first so a same-cycle issue wins
  always_comb begin
    pending_d = pending_q;
    for (int k = 0; k < NWR; k++) begin
      pending_d[waddr_i[k*AW +: AW]] = pending_d[waddr_i[k*AW +: AW]] & ~wr_en_s[k];
    end
    pending_d[issue_rd_i] = pending_d[issue_rd_i] | issue_ok_s;
  end

  // Control and scoreboard registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
    end
  end

  // Array storage: sweep zeroing in INIT, port writes in RUN (higher port index lands last)
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == ST_INIT) begin
        regs_q[cnt_q[AW-1:0]] <= '0;
      end else begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_en_s[k] && !((ZERO_HARD != 0) && (waddr_i[k*AW +: AW] == {AW{1'b0}}))) begin
            regs_q[waddr_i[k*AW +: AW]] <= wdata_i[k*XLEN +: XLEN];
          end
        end
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic            zero_s;
    logic            hit_s;
    logic [XLEN-1:0] byp_s;

    assign ra_s   = raddr_i[j*AW +: AW];
    assign zero_s = (ZERO_HARD != 0) && (ra_s == {AW{1'b0}});

    // Forwarding select: the highest-index matching write port provides the data
    always_comb begin
      hit_s = 1'b0;
      byp_s = '0;
      for (int k = 0; k < NWR; k++) begin
        hit_s = hit_s | (wr_en_s[k] && (waddr_i[k*AW +: AW] == ra_s));
        byp_s = (wr_en_s[k] && (waddr_i[k*AW +: AW] == ra_s)) ? wdata_i[k*XLEN +: XLEN] : byp_s;
      end
    end

    assign rdata_o[j*XLEN +: XLEN] = (!run_s || zero_s) ? {XLEN{1'b0}} :
                                     hit_s             ? byp_s : regs_q[ra_s];
    assign rbusy_o[j] = run_s && pending_q[ra_s] && !hit_s && !zero_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// compared against a behavioural model of the register file and scoreboard.
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, AW = 5, NRD = 2, NWR = 2;

  logic                clk, rst;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                issue;
  logic [AW-1:0]       issue_rd;
  logic                ready;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] mem_m [NREGS];
  bit              pend_m [NREGS];
  bit              ready_m = 1'b0;
  int              cnt_m   = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_HARD(1)) dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy), .issue_i(issue),
    .issue_rd_i(issue_rd), .ready_o(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] wa(input int k);
    return waddr[k*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] ra(input int j);
    return raddr[j*AW +: AW];
  endfunction

  function automatic logic [XLEN-1:0] exp_rdata(input int j);
    logic [XLEN-1:0] v;
    if (!ready_m || ra(j) == 0) return '0;
    v = mem_m[ra(j)];
    for (int k = 0; k < NWR; k++)
      if (we[k] && wa(k) == ra(j)) v = wdata[k*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_rbusy(input int j);
    if (!ready_m || ra(j) == 0 || !pend_m[ra(j)]) return 1'b0;
    for (int k = 0; k < NWR; k++)
      if (we[k] && wa(k) == ra(j)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      ready_m = 1'b0;
      cnt_m   = 0;
      foreach (pend_m[i]) pend_m[i] = 1'b0;
    end else if (!ready_m) begin
      mem_m[cnt_m] = '0;
      cnt_m++;
      if (cnt_m == NREGS) ready_m = 1'b1;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (we[k] && wa(k) != 0) mem_m[wa(k)] = wdata[k*XLEN +: XLEN];
      for (int k = 0; k < NWR; k++)
        if (we[k]) pend_m[wa(k)] = 1'b0;
      if (issue && issue_rd != 0) pend_m[issue_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("ready", {63'd0, ready}, {63'd0, ready_m});
    for (int j = 0; j < NRD; j++) begin
      chk("rdata", {32'd0, rdata[j*XLEN +: XLEN]}, {32'd0, exp_rdata(j)});
      chk("rbusy", {63'd0, rbusy[j]}, {63'd0, exp_rbusy(j)});
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input int k, input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[k] = en;
    waddr[k*AW +: AW] = a;
    wdata[k*XLEN +: XLEN] = d;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; issue = 1'b0; issue_rd = '0;
  endtask

  task automatic rand_inputs(input int amax);
    for (int k = 0; k < NWR; k++)
      wr(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, amax)), $urandom);
    for (int j = 0; j < NRD; j++) raddr[j*AW +: AW] = AW'($urandom_range(0, amax));
    issue    = 1'($urandom_range(0, 1));
    issue_rd = AW'($urandom_range(0, amax));
  endtask

  initial begin
    int n;
    rst = 1'b0; idle(); raddr = '0;
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    @(posedge clk); #1;

    // Reset held 3 cycles, then sweep with writes/issues driven during INIT
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      rand_inputs(NREGS - 1);
      tick();
      n++;
    end
    chk("init_len", 64'(n), 64'd32);
    idle();

    // Every register reads zero after the sweep
    for (int r = 0; r < NREGS; r += 2) begin
      raddr = {AW'(r + 1), AW'(r)};
      #1;
      chk("init_zero0", {32'd0, rdata[31:0]}, 64'd0);
      chk("init_zero1", {32'd0, rdata[63:32]}, 64'd0);
      tick();
    end

    // Dual write conflict on x5
    wr(0, 1'b1, 5'd5, 32'h11111111);
    wr(1, 1'b1, 5'd5, 32'h22222222);
    raddr = {5'd5, 5'd5};
    #1 chk("dual_byp", {32'd0, rdata[31:0]}, 64'h22222222);
    tick();
    idle();
    #1 chk("dual_arr", {32'd0, rdata[31:0]}, 64'h22222222);
    tick();

    // Write to x0 dropped; x7 forwarded
    wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    wr(1, 1'b1, 5'd7, 32'h00001234);
    raddr = {5'd7, 5'd0};
    #1;
    chk("x0_same", {32'd0, rdata[31:0]}, 64'd0);
    chk("x7_byp", {32'd0, rdata[63:32]}, 64'h1234);
    tick();
    idle();
    #1 chk("x0_later", {32'd0, rdata[31:0]}, 64'd0);
    tick();

    // Scoreboard on x9
    raddr = {5'd9, 5'd9};
    issue = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    #1 chk("busy_n1", {63'd0, rbusy[0]}, 64'd1);
    tick();
    tick();
    wr(1, 1'b1, 5'd9, 32'h99);
    #1 chk("busy_wr_byp", {63'd0, rbusy[0]}, 64'd0);
    tick();
    idle();
    #1 chk("busy_cleared", {63'd0, rbusy[0]}, 64'd0);
    tick();
    issue = 1'b1; issue_rd = 5'd9;
    wr(0, 1'b1, 5'd9, 32'h77);
    tick();
    idle();
    #1 chk("busy_set_wins", {63'd0, rbusy[1]}, 64'd1);
    tick();

    // Preload DEADBEEF, x3=ABCD, x4 pending, then 1-cycle reset pulse
    for (int r = 1; r < NREGS; r += 2) begin
      wr(0, 1'b1, AW'(r), 32'hDEADBEEF);
      wr(1, 1'b1, AW'(r + 1), 32'hDEADBEEF);
      tick();
    end
    idle();
    wr(0, 1'b1, 5'd3, 32'h0000ABCD);
    issue = 1'b1; issue_rd = 5'd4;
    tick();
    idle();
    raddr = {5'd4, 5'd3};
    #1;
    chk("x3_pre", {32'd0, rdata[31:0]}, 64'hABCD);
    chk("x4_busy_pre", {63'd0, rbusy[1]}, 64'd1);
    rst = 1'b0;
    wr(1, 1'b1, 5'd3, 32'h5555);
    tick();
    rst = 1'b1;
    idle();
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chk("resweep_len", 64'(n), 64'd32);
    #1;
    chk("x3_post", {32'd0, rdata[31:0]}, 64'd0);
    chk("x4_busy_post", {63'd0, rbusy[1]}, 64'd0);
    tick();

    // Random traffic on a narrow address range, occasional reset
    for (int i = 0; i < 600; i++) begin
      rand_inputs(($urandom_range(0, 3) == 0) ? NREGS - 1 : 7);
      rst = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
